// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit:
//   - funct3 size/sign encodings
//   - FSM state enum
//   - lane-select, load-extension, store-merge and legality helpers
//   Imported by lsu_lane_align and lsu_ctrl.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_STB,
    S_RD_CAP,
    S_WR_SETUP,
    S_WR_STB,
    S_RESP
  } state_t;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] sel_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = sel_byte(w, off);
    h = sel_half(w, off[1]);
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3, input logic [15:0] wdata);
    logic [31:0] r;
    r = w;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) r[31:16] = wdata;
        else        r[15:0]  = wdata;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Misaligned accesses, reserved encodings and unsigned stores are all rejected.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = off[0];
      F3_HU:   bad = we | off[0];
      F3_W:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if
//   Bundles the request/response handshake and the word-memory bus of the LSU.
//   master: the environment (execute stage plus data memory) driving requests
//           and read data.
//   slave : the LSU itself.
//   Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//            resp_valid/resp_rdata/resp_err,
//            mem_write/mem_writeBack/d_addr/dw_data/dr_data.
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_write;
  logic              mem_writeBack;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       dw_data;
  logic [31:0]       dr_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dr_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_writeBack, d_addr, dw_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dr_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_writeBack, d_addr, dw_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Combinational byte/half lane handling.
//   Ports:
//     rdata      in  32  word read from memory
//     offset     in  2   byte offset within the word
//     funct3     in  3   access size / signedness
//     wdata      in  16  low half of the store data (only bits used by SB/SH)
//     load_data  out 32  sign/zero-extended load result
//     merge_data out 32  read word with the store lane(s) replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  always_comb begin
    load_data  = load_extend(rdata, offset, funct3);
    merge_data = store_merge(rdata, offset, funct3, wdata);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
//   Load/store unit between execute and a word-addressed data memory.
//   Converts one byte-addressed RISC-V load/store at a time into timed
//   read (mem_writeBack) and write (mem_write) strobes, with sign/zero
//   extension for loads and read-modify-write for SB/SH.
//   Ports:
//     clk   in  rising-edge clock
//     rst_n in  synchronous active-low reset
//     bus   lsu_ctrl_if.slave  request/response handshake and memory bus
//   All interface outputs are registered.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_ctrl_if.slave      bus
);

  state_t      state;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Address bits above the memory size are ignored so accesses wrap.
  logic addr_unused;
  assign addr_unused = ^bus.req_addr[31:ADDR_W+2];

  lsu_lane_align u_align (
    .rdata      (bus.dr_data),
    .offset     (off_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      f3_q              <= '0;
      we_q              <= 1'b0;
      off_q             <= '0;
      wdata_q           <= '0;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_err      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_writeBack <= 1'b0;
      bus.d_addr        <= '0;
      bus.dw_data       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            f3_q          <= bus.req_funct3;
            we_q          <= bus.req_we;
            off_q         <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata[15:0];
            bus.d_addr    <= bus.req_addr[ADDR_W+1:2];
            bus.req_ready <= 1'b0;
            if (req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= S_RESP;
            end else if (!bus.req_we || bus.req_funct3 != F3_W) begin
              // Loads and sub-word stores both need the current word first.
              state <= S_RD_SETUP;
            end else begin
              bus.dw_data <= bus.req_wdata;
              state       <= S_WR_SETUP;
            end
          end
        end
        S_RD_SETUP: begin
          bus.mem_writeBack <= 1'b1;
          state             <= S_RD_STB;
        end
        S_RD_STB: begin
          bus.mem_writeBack <= 1'b0;
          state             <= S_RD_CAP;
        end
        S_RD_CAP: begin
          if (we_q) begin
            bus.dw_data <= merge_data;
            state       <= S_WR_SETUP;
          end else begin
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_data;
            state          <= S_RESP;
          end
        end
        S_WR_SETUP: begin
          bus.mem_write <= 1'b1;
          state         <= S_WR_STB;
        end
        S_WR_STB: begin
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          state          <= S_RESP;
        end
        S_RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
          state          <= S_IDLE;
        end
        default: begin
          bus.mem_write     <= 1'b0;
          bus.mem_writeBack <= 1'b0;
          bus.resp_valid    <= 1'b0;
          bus.req_ready     <= 1'b1;
          state             <= S_IDLE;
        end
      endcase
    end
  end

endmodule
